// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the fetch-stage PC sequencer
//
// Purpose : state encoding, default sequential step and target alignment helper.
// Contents: pc_state_e, STEP_DEFAULT, ALIGN_MASK, is_aligned().
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } pc_state_e;

    localparam int unsigned STEP_DEFAULT = 4;

    // Instruction addresses are word aligned; these low bits must be zero.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next fetch address priority mux with alignment check
//
// Purpose : picks the next fetch address: this-cycle redirect (branch over jump),
//           else a pending redirect, else current address + STEP.
// Ports   : br_valid_i/br_target_i, jmp_valid_i/jmp_target_i  redirect requests
//           pend_i/pend_addr_i                                 latched redirect
//           cur_addr_i                                         current fetch address
//           redir_o/redir_addr_o   accepted (aligned) this-cycle redirect
//           next_addr_o            address for the fetch after an ack
//           discard_o              in-flight fetch must not be delivered
//           misalign_o             winning redirect target is not word aligned
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned STEP   = STEP_DEFAULT
) (
    input  logic              br_valid_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              jmp_valid_i,
    input  logic [ADDR_W-1:0] jmp_target_i,
    input  logic              pend_i,
    input  logic [ADDR_W-1:0] pend_addr_i,
    input  logic [ADDR_W-1:0] cur_addr_i,
    output logic              redir_o,
    output logic [ADDR_W-1:0] redir_addr_o,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              discard_o,
    output logic              misalign_o
);

    logic sel_valid;
    logic sel_aligned;

    always_comb begin
        sel_valid    = br_valid_i | jmp_valid_i;
        redir_addr_o = br_valid_i ? br_target_i : jmp_target_i;
        sel_aligned  = is_aligned(redir_addr_o[1:0]);
        // A misaligned winner is dropped outright; it does not fall back to the jump.
        redir_o      = sel_valid & sel_aligned;
        misalign_o   = sel_valid & ~sel_aligned;
        discard_o    = redir_o | pend_i;
        if (redir_o) begin
            next_addr_o = redir_addr_o;
        end else if (pend_i) begin
            next_addr_o = pend_addr_i;
        end else begin
            next_addr_o = cur_addr_i + ADDR_W'(STEP);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - flow-controlled program counter and fetch sequencer
//
// Purpose : owns the PC, issues fetches over imem_req/imem_ack, applies
//           branch/jump redirects, stall, halt/resume and alignment checking.
// Ports   : clka, rsta (sync active-low)            clock and reset
//           stall, halt, resume                     flow control
//           br_valid/br_target, jmp_valid/jmp_target redirects
//           imem_req, imem_addr, imem_ack           instruction memory handshake
//           pc_out, pc_valid                        delivered fetch address
//           halted, misalign_err                    status (misalign_err sticky)
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       STEP      = STEP_DEFAULT
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              halt,
    input  logic              resume,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_valid,
    output logic              halted,
    output logic              misalign_err
);

    pc_state_e         state_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic              pc_valid_q;
    logic              halted_q;
    logic              err_q;
    logic              pend_q;
    logic [ADDR_W-1:0] pend_addr_q;

    logic              redir;
    logic [ADDR_W-1:0] redir_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              discard;
    logic              misalign;

    pc_next_sel #(
        .ADDR_W (ADDR_W),
        .STEP   (STEP)
    ) u_next_sel (
        .br_valid_i   (br_valid),
        .br_target_i  (br_target),
        .jmp_valid_i  (jmp_valid),
        .jmp_target_i (jmp_target),
        .pend_i       (pend_q),
        .pend_addr_i  (pend_addr_q),
        .cur_addr_i   (addr_q),
        .redir_o      (redir),
        .redir_addr_o (redir_addr),
        .next_addr_o  (next_addr),
        .discard_o    (discard),
        .misalign_o   (misalign)
    );

    always_ff @(posedge clka) begin
        if (!rsta) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            addr_q      <= RESET_VEC;
            pc_out_q    <= '0;
            pc_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            pc_valid_q <= 1'b0;
            if (misalign) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_REQ;
                    req_q   <= 1'b1;
                end
                ST_REQ: begin
                    // The request is never withdrawn; everything waits for the ack.
                    if (imem_ack) begin
                        if (!discard) begin
                            pc_out_q   <= addr_q;
                            pc_valid_q <= 1'b1;
                        end
                        addr_q <= next_addr;
                        pend_q <= 1'b0;
                        if (err_q || misalign || halt) begin
                            state_q  <= ST_HALT;
                            req_q    <= 1'b0;
                            halted_q <= 1'b1;
                        end else if (stall) begin
                            state_q <= ST_STALL;
                            req_q   <= 1'b0;
                        end
                    end else if (redir) begin
                        pend_q      <= 1'b1;
                        pend_addr_q <= redir_addr;
                    end
                end
                ST_STALL: begin
                    if (redir) begin
                        addr_q <= redir_addr;
                    end
                    if (err_q || misalign || halt) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (!stall) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (redir) begin
                        addr_q <= redir_addr;
                    end
                    if (resume && !err_q && !misalign) begin
                        state_q  <= ST_REQ;
                        req_q    <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign pc_out       = pc_out_q;
    assign pc_valid     = pc_valid_q;
    assign halted       = halted_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clka = 1'b0;
    logic        rsta = 1'b0;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        jmp_valid = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic        imem_ack = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        halted;
    logic        misalign_err;

    int total = 0;
    int bad = 0;

    // Reference model: a fetcher that is either not yet started, fetching,
    // halted, or (started, not fetching, not halted) waiting out a stall.
    bit          m_run, m_req, m_halt, m_pend, m_pcv, m_err;
    logic [31:0] m_addr, m_pend_addr, m_pc_out;

    pc_sequencer #(.ADDR_W(32), .RESET_VEC(32'h0), .STEP(4)) dut (
        .clka(clka), .rsta(rsta), .stall(stall),
        .br_valid(br_valid), .br_target(br_target),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .halt(halt), .resume(resume),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .pc_out(pc_out), .pc_valid(pc_valid),
        .halted(halted), .misalign_err(misalign_err)
    );

    always #5 clka = ~clka;

    task automatic model_step();
        bit          has_t, t_ok, new_err;
        logic [31:0] t;
        if (!rsta) begin
            m_run = 0; m_req = 0; m_halt = 0; m_pend = 0; m_pcv = 0; m_err = 0;
            m_addr = 32'h0; m_pc_out = 32'h0;
            return;
        end
        has_t   = br_valid || jmp_valid;
        t       = br_valid ? br_target : jmp_target;
        t_ok    = has_t && (t % 4 == 0);
        new_err = m_err || (has_t && (t % 4 != 0));
        m_pcv   = 0;
        if (!m_run) begin
            m_run = 1; m_req = 1;
        end else if (m_req) begin
            if (imem_ack) begin
                if (!(m_pend || t_ok)) begin
                    m_pcv = 1; m_pc_out = m_addr;
                end
                m_addr = t_ok ? t : (m_pend ? m_pend_addr : m_addr + 32'd4);
                m_pend = 0;
                if (new_err || halt) begin
                    m_req = 0; m_halt = 1;
                end else if (stall) begin
                    m_req = 0;
                end
            end else if (t_ok) begin
                m_pend = 1; m_pend_addr = t;
            end
        end else if (m_halt) begin
            if (t_ok) m_addr = t;
            if (resume && !new_err) begin
                m_halt = 0; m_req = 1;
            end
        end else begin
            if (t_ok) m_addr = t;
            if (new_err || halt) m_halt = 1;
            else if (!stall) m_req = 1;
        end
        m_err = new_err;
    endtask

    task automatic tick();
        model_step();
        @(posedge clka);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; br_valid = 0; jmp_valid = 0; halt = 0; resume = 0; imem_ack = 0;
    endtask

    task automatic reset_and_start();
        clear_inputs();
        rsta = 0;
        tick();
        rsta = 1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rsta = 0;
        tick();
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        total++; if (pc_valid !== 1'b0) begin bad++; $display("FAIL reset_pcv got=%b exp=0", pc_valid); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc_out got=%h exp=0", pc_out); end
        total++; if (halted !== 1'b0 || misalign_err !== 1'b0) begin bad++; $display("FAIL reset_status got=%b%b exp=00", halted, misalign_err); end
    endtask

    task automatic test_sequential();
        reset_and_start();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL seq_start got=%b/%h exp=1/0", imem_req, imem_addr); end
        imem_ack = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (imem_addr !== 32'(4 * (i + 1))) begin bad++; $display("FAIL seq_addr got=%h exp=%h", imem_addr, 32'(4 * (i + 1))); end
            total++; if (pc_valid !== 1'b1 || pc_out !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc got=%b/%h exp=1/%h", pc_valid, pc_out, 32'(4 * i)); end
        end
        imem_ack = 0;
    endtask

    task automatic test_delayed_ack_redirect();
        reset_and_start();
        imem_ack = 1;
        tick();
        tick();
        imem_ack = 0;
        br_valid = 1; br_target = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tick();
            br_valid = 0;
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || pc_valid !== 1'b0) begin bad++; $display("FAIL dly_hold got=%b/%h/%b exp=1/8/0", imem_req, imem_addr, pc_valid); end
        end
        imem_ack = 1;
        tick();
        total++; if (pc_valid !== 1'b0 || imem_addr !== 32'h100) begin bad++; $display("FAIL dly_discard got=%b/%h exp=0/100", pc_valid, imem_addr); end
        tick();
        total++; if (pc_valid !== 1'b1 || pc_out !== 32'h100) begin bad++; $display("FAIL dly_target got=%b/%h exp=1/100", pc_valid, pc_out); end
        imem_ack = 0;
    endtask

    task automatic test_same_cycle_redirect();
        reset_and_start();
        imem_ack = 1;
        tick();
        br_valid = 1; br_target = 32'h40; jmp_valid = 1; jmp_target = 32'h80;
        tick();
        br_valid = 0; jmp_valid = 0;
        total++; if (pc_valid !== 1'b0 || imem_addr !== 32'h40) begin bad++; $display("FAIL same_redir got=%b/%h exp=0/40", pc_valid, imem_addr); end
        tick();
        total++; if (pc_valid !== 1'b1 || pc_out !== 32'h40) begin bad++; $display("FAIL same_next got=%b/%h exp=1/40", pc_valid, pc_out); end
        imem_ack = 0;
    endtask

    task automatic test_stall();
        reset_and_start();
        imem_ack = 1;
        for (int i = 0; i < 4; i++) tick();
        stall = 1;
        tick();
        total++; if (pc_valid !== 1'b1 || pc_out !== 32'h10 || imem_req !== 1'b0 || imem_addr !== 32'h14) begin bad++; $display("FAIL stall_enter got=%b/%h/%b/%h exp=1/10/0/14", pc_valid, pc_out, imem_req, imem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (imem_req !== 1'b0 || pc_valid !== 1'b0) begin bad++; $display("FAIL stall_hold got=%b/%b exp=0/0", imem_req, pc_valid); end
        end
        stall = 0;
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h14 || pc_valid !== 1'b0) begin bad++; $display("FAIL stall_exit got=%b/%h/%b exp=1/14/0", imem_req, imem_addr, pc_valid); end
        tick();
        total++; if (pc_valid !== 1'b1 || pc_out !== 32'h14) begin bad++; $display("FAIL stall_resume got=%b/%h exp=1/14", pc_valid, pc_out); end
        imem_ack = 0;
    endtask

    task automatic test_misalign();
        reset_and_start();
        jmp_valid = 1; jmp_target = 32'h102;
        tick();
        jmp_valid = 0;
        total++; if (misalign_err !== 1'b1 || imem_req !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b/%b exp=1/1", misalign_err, imem_req); end
        imem_ack = 1;
        tick();
        imem_ack = 0;
        total++; if (halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h4) begin bad++; $display("FAIL mis_halt got=%b/%b/%h exp=1/0/4", halted, imem_req, imem_addr); end
        total++; if (pc_valid !== m_pcv) begin bad++; $display("FAIL mis_pcv got=%b exp=%b", pc_valid, m_pcv); end
        resume = 1;
        tick();
        tick();
        resume = 0;
        total++; if (halted !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL mis_resume got=%b/%b exp=1/0", halted, imem_req); end
        rsta = 0;
        tick();
        total++; if (misalign_err !== 1'b0 || halted !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL mis_reset got=%b/%b/%h exp=0/0/0", misalign_err, halted, imem_addr); end
        rsta = 1;
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL mis_restart got=%b/%h exp=1/0", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        reset_and_start();
        imem_ack = 1;
        jmp_valid = 1; jmp_target = 32'hFFFF_FFFC;
        tick();
        jmp_valid = 0;
        total++; if (imem_addr !== 32'hFFFF_FFFC || pc_valid !== 1'b0) begin bad++; $display("FAIL wrap_jump got=%h/%b exp=fffffffc/0", imem_addr, pc_valid); end
        tick();
        total++; if (imem_addr !== 32'h0 || pc_out !== 32'hFFFF_FFFC || pc_valid !== 1'b1 || misalign_err !== 1'b0) begin bad++; $display("FAIL wrap_next got=%h/%h/%b/%b exp=0/fffffffc/1/0", imem_addr, pc_out, pc_valid, misalign_err); end
        imem_ack = 0;
    endtask

    task automatic test_random();
        int prev_pcv;
        prev_pcv = 0;
        reset_and_start();
        for (int i = 0; i < 600; i++) begin
            rsta       = ($urandom_range(0, 40) != 0);
            imem_ack   = ($urandom_range(0, 2) != 0);
            stall      = ($urandom_range(0, 4) == 0);
            halt       = ($urandom_range(0, 15) == 0);
            resume     = ($urandom_range(0, 3) == 0);
            br_valid   = ($urandom_range(0, 7) == 0);
            jmp_valid  = ($urandom_range(0, 7) == 0);
            br_target  = $urandom & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            jmp_target = $urandom & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            tick();
            total++;
            if (imem_req !== m_req || imem_addr !== m_addr || pc_valid !== m_pcv ||
                pc_out !== m_pc_out || halted !== m_halt || misalign_err !== m_err) begin
                bad++;
                $display("FAIL rand cyc=%0d got req=%b addr=%h pcv=%b pc=%h hlt=%b err=%b exp req=%b addr=%h pcv=%b pc=%h hlt=%b err=%b",
                         i, imem_req, imem_addr, pc_valid, pc_out, halted, misalign_err,
                         m_req, m_addr, m_pcv, m_pc_out, m_halt, m_err);
            end
        end
        clear_inputs();
        rsta = 1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_delayed_ack_redirect();
        test_same_cycle_redirect();
        test_stall();
        test_misalign();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
